// File: rtl/draw_arbiter_pkg.sv
// Shared constants and types for the draw arbiter: FSM state encoding,
// screen geometry, coordinate/colour widths and the off-screen test.
package draw_arbiter_pkg;

  localparam int X_W        = 8;
  localparam int Y_W        = 7;
  localparam int COLOUR_W   = 3;
  localparam int GRANT_W    = 2;
  localparam int CLIP_CNT_W = 16;

  localparam logic [X_W-1:0] SCREEN_W = 8'd160;
  localparam logic [Y_W-1:0] SCREEN_H = 7'd120;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_RUN    = 2'd1;
  localparam arb_state_t ST_FINISH = 2'd2;
  localparam arb_state_t ST_DRAIN  = 2'd3;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } vga_pix_t;

  function automatic logic off_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x >= SCREEN_W) || (y >= SCREEN_H);
  endfunction

endpackage

// File: rtl/draw_arbiter_rr_pick.sv
// Round-robin request selector: first requester searching from last+1 (mod N_ENG).
module rr_pick
  import draw_arbiter_pkg::*;
#(
  parameter int N_ENG = 3
) (
  input  logic [N_ENG-1:0]   req,
  input  logic [GRANT_W-1:0] last,
  output logic               valid,
  output logic [GRANT_W-1:0] index
);

  // Offset k=1 is the highest priority; the !valid guard keeps the first hit.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = 1; k <= N_ENG; k++) begin
      for (int i = 0; i < N_ENG; i++) begin
        if (!valid && req[i] && (((int'(last) + k) % N_ENG) == i)) begin
          valid = 1'b1;
          index = GRANT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates N_ENG drawing engines onto one VGA plot port, one run at a time.
// Define ARB_CLIP_EN to suppress and count off-screen plots.
//
// state  | meaning
// IDLE   | waiting for a request; round-robin pick loads grant
// RUN    | granted engine started, its plots forwarded to VGA
// FINISH | single cycle: ack pulse, last := grant
// DRAIN  | start dropped, waiting for granted engine's done to fall
module draw_arbiter
  import draw_arbiter_pkg::*;
#(
  parameter int N_ENG = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_ENG-1:0]            req,
  output logic [N_ENG-1:0]            ack,
  output logic [N_ENG-1:0]            eng_start,
  input  logic [N_ENG-1:0]            eng_done,
  input  logic [X_W*N_ENG-1:0]        eng_x,
  input  logic [Y_W*N_ENG-1:0]        eng_y,
  input  logic [COLOUR_W*N_ENG-1:0]   eng_colour,
  input  logic [N_ENG-1:0]            eng_plot,
  output logic [X_W-1:0]              vga_x,
  output logic [Y_W-1:0]              vga_y,
  output logic [COLOUR_W-1:0]         vga_colour,
  output logic                        vga_plot,
  output logic                        busy,
  output logic [GRANT_W-1:0]          grant,
  output logic [CLIP_CNT_W-1:0]       clip_cnt
);

  localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(N_ENG - 1);

  arb_state_t         state;
  logic [GRANT_W-1:0] last;
  logic               pick_valid;
  logic [GRANT_W-1:0] pick_index;
  vga_pix_t           sel_pix;
  logic               sel_plot;
  logic               sel_done;
  logic               clip_hit;

  rr_pick #(
    .N_ENG (N_ENG)
  ) u_rr_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .index (pick_index)
  );

  // Only the granted engine's slice is ever looked at.
  always_comb begin
    sel_pix  = '0;
    sel_plot = 1'b0;
    sel_done = 1'b0;
    for (int i = 0; i < N_ENG; i++) begin
      if (grant == GRANT_W'(i)) begin
        sel_pix.x      = eng_x[X_W*i +: X_W];
        sel_pix.y      = eng_y[Y_W*i +: Y_W];
        sel_pix.colour = eng_colour[COLOUR_W*i +: COLOUR_W];
        sel_plot       = eng_plot[i];
        sel_done       = eng_done[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      last  <= LAST_RST;
      grant <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant <= pick_index;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (sel_done) state <= ST_FINISH;
        end
        ST_FINISH: begin
          last  <= grant;
          state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!sel_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from the state register so reset clears them asynchronously.
  always_comb begin
    eng_start = '0;
    ack       = '0;
    for (int i = 0; i < N_ENG; i++) begin
      if (grant == GRANT_W'(i)) begin
        eng_start[i] = (state == ST_RUN) || (state == ST_FINISH);
        ack[i]       = (state == ST_FINISH);
      end
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef ARB_CLIP_EN
  assign clip_hit = off_screen(sel_pix.x, sel_pix.y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_cnt <= '0;
    end else if ((state == ST_RUN) && sel_plot && clip_hit && (clip_cnt != '1)) begin
      clip_cnt <= clip_cnt + 1'b1;
    end
  end
`else
  assign clip_hit = 1'b0;
  assign clip_cnt = '0;
`endif

  // Coordinates hold their last RUN sample; the strobe only survives a RUN sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else if (state == ST_RUN) begin
      vga_x      <= sel_pix.x;
      vga_y      <= sel_pix.y;
      vga_colour <= sel_pix.colour;
      vga_plot   <= sel_plot & ~clip_hit;
    end else begin
      vga_plot   <= 1'b0;
    end
  end

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 SHALL have parameter: N_ENG, 3, number of drawing engines sharing the VGA plot port (2..4).
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_ENG  host request to run engine i; held high until ack[i].
- ack  output  N_ENG  one-cycle pulse when engine i's run is complete.
- eng_start  output  N_ENG  start to engine i; level, held until that engine's done.
- eng_done  input  N_ENG  done from engine i.
- eng_x  input  8*N_ENG  x of engine i at bits [8i+7:8i].
- eng_y  input  7*N_ENG  y of engine i at bits [7i+6:7i].
- eng_colour  input  3*N_ENG  colour of engine i at bits [3i+2:3i].
- eng_plot  input  N_ENG  plot strobe of engine i.
- vga_x  output  8  to VGA adapter.
- vga_y  output  7  to VGA adapter.
- vga_colour  output  3  to VGA adapter.
- vga_plot  output  1  to VGA adapter.
- busy  output  1  high whenever the FSM is not in IDLE.
- grant  output  2  index of the engine currently or last granted.
- clip_cnt  output  16  count of suppressed out-of-screen plots.

Function
REQ-003 SHALL implement FSM states IDLE, RUN, FINISH, DRAIN.
REQ-004 IDLE: if any req bit is high, SHALL select the first requesting index searching round-robin from last+1 (mod N_ENG), load grant, and enter RUN next cycle; otherwise SHALL stay in IDLE.
REQ-005 eng_start[grant] SHALL be high in RUN and FINISH only; all other eng_start bits SHALL be 0.
REQ-006 RUN: on eng_done[grant]=1 SHALL enter FINISH; eng_done of non-granted engines SHALL be ignored.
REQ-007 FINISH: SHALL last exactly one cycle, pulse ack[grant]=1, update last:=grant, and enter DRAIN.
REQ-008 DRAIN: eng_start SHALL be 0; SHALL return to IDLE when eng_done[grant]=0.
REQ-009 vga_x, vga_y, vga_colour, vga_plot SHALL be registered copies of the granted engine's slice, one cycle latency, sampled while in RUN.
REQ-010 vga_plot SHALL be 0 in the cycle after any sample taken outside RUN; plots from non-granted engines SHALL never reach the VGA port.
REQ-011 req changes outside IDLE SHALL not affect the current run; a req dropped before ack SHALL not abort it.
REQ-012 Minimum turnaround: req high in IDLE -> eng_start high 1 cycle later; back-to-back requests from different engines SHALL be served with no starvation (each waits at most N_ENG-1 runs).
REQ-013 clip_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-014 rst high SHALL asynchronously force: state=IDLE, last=N_ENG-1 (engine 0 first), grant=0, eng_start=0, ack=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, clip_cnt=0.
REQ-015 rst mid-run SHALL drop eng_start immediately with no ack; the aborted engine is not re-run unless re-requested.

Configuration
REQ-016 With ARB_CLIP_EN defined: a granted plot with x>=160 or y>=119+1 SHALL produce vga_plot=0 and increment clip_cnt; coordinates SHALL still be registered.
REQ-017 Without ARB_CLIP_EN: all granted plots SHALL pass unchanged; clip_cnt SHALL be constant 0.

Structure
REQ-018 A shared package SHALL hold the FSM state enum, SCREEN_W=160, SCREEN_H=120, and coordinate/colour width constants.
REQ-019 The round-robin selector SHALL be a sub-module rr_pick (inputs req, last; outputs valid, index).

Verification
REQ-020 Reset then req=3'b001; engine 0 plots (5,7,colour 3) -> vga 5/7/3 with vga_plot=1 one cycle later; done -> ack=3'b001 single pulse.
REQ-021 req=3'b111 held throughout -> grants in order 0,1,2,0; each ack preceded by its engine's done.
REQ-022 Engine 1 plots while engine 0 granted -> vga_plot stays 0 for engine 1's strobes.
REQ-023 ARB_CLIP_EN defined, granted plot at (160,10) then (159,119) -> first suppressed with clip_cnt=1, second plotted.
REQ-024 rst asserted in RUN -> eng_start=0 and vga_plot=0 same cycle, no ack, busy=0.
REQ-025 eng_done held high 5 cycles after FINISH -> FSM stays in DRAIN 5 cycles, no second ack, next grant only after done falls.
